mem_arb: RTL and testbench

Two-master arbiter that shares the single-port system memory between instruction fetch (IF) and the load/store path of the execute stage (LS). It accepts one request at a time, drives a registered memory request, waits for the memory's in-order response and routes it back to the owning master. It also generates `hold_flag_o` toward `ctrl` so the PC freezes while a data access owns the memory. A starvation counter prevents LS traffic from locking out fetch indefinitely.

---
 rtl/mem_arb.sv | 182 ++++++++++++++++++
 tb/tb_mem_arb.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb
//
// Shares the single-port system memory between instruction fetch (IF) and the
// execute-stage load/store path (LS). One transaction is outstanding at a time.
// The winner's request is latched into registered mem_* outputs. The in-order
// response is routed back to whichever master owns the transaction.
//
// LS wins arbitration by default. IF wins when it is the only requester. IF
// also wins when ls_run shows LS has taken MAX_LS_RUN grants in a row while IF
// was waiting.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   if_req_i / if_addr_i          fetch request (held until if_gnt_o)
//   if_gnt_o                      fetch accepted (combinational pulse)
//   if_rvalid_o / if_rdata_o      fetch response (combinational pulse)
//   ls_req_i / ls_we_i / ls_addr_i / ls_wdata_i / ls_be_i
//                                 data request (held until ls_gnt_o)
//   ls_gnt_o                      data request accepted (combinational pulse)
//   ls_rvalid_o / ls_rdata_o      load data or store ack (rdata 0 for stores)
//   mem_req_o .. mem_be_o         registered memory request
//   mem_gnt_i                     memory accepted mem_req_o
//   mem_rvalid_i / mem_rdata_i    memory response
//   hold_flag_o                   PC stall request toward ctrl
//   dbg_state                     current FSM state (IDLE=0, REQ=1, WAIT=2)
//   dbg_ls_run                    consecutive LS grants while IF was waiting
//
// Handshake semantics
//   Master side: a master raises *_req_i with stable fields and keeps them
//   until it sees *_gnt_o in the same cycle. The transfer happens on the
//   clock edge that ends that cycle. Dropping req before gnt withdraws it
//   silently.
//   Memory side: mem_req_o and its fields are held stable until the edge on
//   which mem_gnt_i is high. Exactly one mem_rvalid_i is expected afterwards.
//   mem_gnt_i and mem_rvalid_i are ignored in any state that does not expect
//   them.
// -----------------------------------------------------------------------------
module mem_arb #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_LS_RUN = 4
) (
  input  logic                            clk,
  input  logic                            rst,

  input  logic                            if_req_i,
  input  logic [AW-1:0]                   if_addr_i,
  output logic                            if_gnt_o,
  output logic                            if_rvalid_o,
  output logic [DW-1:0]                   if_rdata_o,

  input  logic                            ls_req_i,
  input  logic                            ls_we_i,
  input  logic [AW-1:0]                   ls_addr_i,
  input  logic [DW-1:0]                   ls_wdata_i,
  input  logic [DW/8-1:0]                 ls_be_i,
  output logic                            ls_gnt_o,
  output logic                            ls_rvalid_o,
  output logic [DW-1:0]                   ls_rdata_o,

  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic [AW-1:0]                   mem_addr_o,
  output logic [DW-1:0]                   mem_wdata_o,
  output logic [DW/8-1:0]                 mem_be_o,
  input  logic                            mem_gnt_i,
  input  logic                            mem_rvalid_i,
  input  logic [DW-1:0]                   mem_rdata_i,

  output logic                            hold_flag_o,

  output logic [1:0]                      dbg_state,
  output logic [$clog2(MAX_LS_RUN+1)-1:0] dbg_ls_run
);

  localparam int RW = $clog2(MAX_LS_RUN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_t        state_q, state_d;
  logic          owner_q;
  logic [RW-1:0] ls_run_q;

  logic arb_en;
  logic pick_ls;
  logic pick_if;
  logic accept;
  logic rsp;

  // Arbitration is possible when idle, or on the response cycle so that a
  // new request can be issued back-to-back. Gated by rst so no grant leaks
  // out while the block is held in reset.
  assign arb_en  = rst & ((state_q == S_IDLE) ||
                          ((state_q == S_WAIT) && mem_rvalid_i));
  assign pick_ls = ls_req_i & ~(if_req_i & (ls_run_q == RW'(MAX_LS_RUN)));
  assign pick_if = if_req_i & ~pick_ls;

  assign ls_gnt_o = arb_en & pick_ls;
  assign if_gnt_o = arb_en & pick_if;
  assign accept   = ls_gnt_o | if_gnt_o;

  // Response routing: only the owner ever sees rvalid. Store responses carry
  // no data; mem_we_o still holds the owner's we during WAIT.
  assign rsp         = (state_q == S_WAIT) & mem_rvalid_i;
  assign if_rvalid_o = rsp & (owner_q == OWN_IF);
  assign ls_rvalid_o = rsp & (owner_q == OWN_LS);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign ls_rdata_o  = (ls_rvalid_o && !mem_we_o) ? mem_rdata_i : '0;

  assign hold_flag_o = ls_req_i | ((state_q != S_IDLE) & (owner_q == OWN_LS));

  assign dbg_state  = state_q;
  assign dbg_ls_run = ls_run_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept)       state_d = S_REQ;
      S_REQ:  if (mem_gnt_i)    state_d = S_WAIT;
      S_WAIT: if (mem_rvalid_i) state_d = accept ? S_REQ : S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request registers, owner and starvation counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= OWN_IF;
      ls_run_q    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
    end else begin
      if (accept) begin
        mem_req_o <= 1'b1;
        if (ls_gnt_o) begin
          owner_q     <= OWN_LS;
          mem_we_o    <= ls_we_i;
          mem_addr_o  <= ls_addr_i;
          mem_wdata_o <= ls_wdata_i;
          mem_be_o    <= ls_be_i;
        end else begin
          owner_q     <= OWN_IF;
          mem_we_o    <= 1'b0;
          mem_addr_o  <= if_addr_i;
          mem_wdata_o <= '0;
          mem_be_o    <= '1;
        end
        // Count only LS grants that made a waiting fetch wait longer.
        if (ls_gnt_o && if_req_i) begin
          if (ls_run_q != RW'(MAX_LS_RUN)) begin
            ls_run_q <= ls_run_q + 1'b1;
          end
        end else begin
          ls_run_q <= '0;
        end
      end else if ((state_q == S_REQ) && mem_gnt_i) begin
        mem_req_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_LS_RUN = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic          if_gnt_o, if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          ls_req_i = 1'b0;
  logic          ls_we_i = 1'b0;
  logic [AW-1:0] ls_addr_i = '0;
  logic [DW-1:0] ls_wdata_i = '0;
  logic [3:0]    ls_be_i = '0;
  logic          ls_gnt_o, ls_rvalid_o;
  logic [DW-1:0] ls_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [3:0]    mem_be_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          hold_flag_o;
  logic [1:0]    dbg_state;
  logic [2:0]    dbg_ls_run;

  mem_arb #(.AW(AW), .DW(DW), .MAX_LS_RUN(MAX_LS_RUN)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_be_i(ls_be_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .hold_flag_o(hold_flag_o),
    .dbg_state(dbg_state), .dbg_ls_run(dbg_ls_run)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Vector record: request inputs, memory behaviour, expected results.
  typedef struct {
    logic        if_req;
    logic        ls_req;
    logic        we;
    logic [31:0] if_addr;
    logic [31:0] ls_addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    logic [31:0] rdata;
    logic        exp_ls;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  // ---------------------------------------------------------------- drivers
  // All driver tasks start and end at "#1 after posedge".
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    if_req_i   = v.if_req;
    ls_req_i   = v.ls_req;
    ls_we_i    = v.we;
    if_addr_i  = v.if_addr;
    ls_addr_i  = v.ls_addr;
    ls_wdata_i = v.wdata;
    ls_be_i    = v.be;
    @(negedge clk);
    check({nm, " ls_gnt"}, 32'(ls_gnt_o), 32'(v.exp_ls));
    check({nm, " if_gnt"}, 32'(if_gnt_o), 32'(!v.exp_ls));
    check({nm, " hold_accept"}, 32'(hold_flag_o), 32'(v.ls_req));
    step();
    if_req_i  = 1'b0;
    ls_req_i  = 1'b0;
    mem_gnt_i = (v.waits == 0);
    @(negedge clk);
    check({nm, " mem_req"},   32'(mem_req_o), 32'd1);
    check({nm, " mem_addr"},  mem_addr_o, v.exp_addr);
    check({nm, " mem_we"},    32'(mem_we_o), 32'(v.exp_we));
    check({nm, " mem_wdata"}, mem_wdata_o, v.exp_wdata);
    check({nm, " mem_be"},    32'(mem_be_o), 32'(v.exp_be));
    check({nm, " hold_req"},  32'(hold_flag_o), 32'(v.exp_ls));
    for (int w = 0; w < v.waits; w++) begin
      step();
      mem_gnt_i = (w == v.waits - 1);
      @(negedge clk);
      check({nm, " mem_req_held"},  32'(mem_req_o), 32'd1);
      check({nm, " mem_addr_held"}, mem_addr_o, v.exp_addr);
    end
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = v.rdata;
    @(negedge clk);
    check({nm, " mem_req_dropped"}, 32'(mem_req_o), 32'd0);
    check({nm, " ls_rvalid"}, 32'(ls_rvalid_o), 32'(v.exp_ls));
    check({nm, " if_rvalid"}, 32'(if_rvalid_o), 32'(!v.exp_ls));
    check({nm, " ls_rdata"},  ls_rdata_o, v.exp_ls ? v.exp_rdata : 32'h0);
    check({nm, " if_rdata"},  if_rdata_o, v.exp_ls ? 32'h0 : v.exp_rdata);
    check({nm, " hold_rsp"},  32'(hold_flag_o), 32'(v.exp_ls));
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    @(negedge clk);
    check({nm, " idle_after"}, 32'(dbg_state), 32'd0);
    step();
  endtask

  // ---------------------------------------------------------------- test
  logic exp_order[6];
  logic [2:0] exp_run[6];
  int   n_gr;
  logic pend, pend_n;

  initial begin
    //                 ifr   lsr   we    if_addr       ls_addr       wdata         be    w  rdata         exp_ls exp_addr     we    exp_wdata     be    exp_rdata
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        4'h0, 0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 1'b0, 32'h0,        4'hF, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0180, 32'h0000_0200, 32'h0,        4'hF, 2, 32'hCAFE_F00D, 1'b1, 32'h0000_0200, 1'b0, 32'h0,        4'hF, 32'hCAFE_F00D};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h0000_0040, 32'h1234_5678, 4'h3, 0, 32'hFFFF_FFFF, 1'b1, 32'h0000_0040, 1'b1, 32'h1234_5678, 4'h3, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_0300, 32'h0,        4'hC, 1, 32'hA5A5_5A5A, 1'b1, 32'h0000_0300, 1'b0, 32'h0,        4'hC, 32'hA5A5_5A5A};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0,        32'h0,        4'h0, 3, 32'h0000_0013, 1'b0, 32'h0000_0104, 1'b0, 32'h0,        4'hF, 32'h0000_0013};

    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_run   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

    // Reset state, with an LS request pending to see hold follow it
    ls_req_i = 1'b1;
    if_req_i = 1'b1;
    #12;
    check("rst hold_follows_ls_req", 32'(hold_flag_o), 32'd1);
    check("rst ls_gnt", 32'(ls_gnt_o), 32'd0);
    check("rst if_gnt", 32'(if_gnt_o), 32'd0);
    check("rst mem_req", 32'(mem_req_o), 32'd0);
    check("rst mem_be", 32'(mem_be_o), 32'd0);
    check("rst state", 32'(dbg_state), 32'd0);
    check("rst ls_run", 32'(dbg_ls_run), 32'd0);
    ls_req_i = 1'b0;
    if_req_i = 1'b0;
    step();
    rst = 1'b1;
    step();

    // Table-driven transactions
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: LS load with 2 gnt wait states, IF accepted on ls_rvalid
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0180;
    ls_req_i  = 1'b1;
    ls_we_i   = 1'b0;
    ls_addr_i = 32'h0000_0200;
    ls_be_i   = 4'hF;
    @(negedge clk);
    check("b2b ls_gnt_first", 32'(ls_gnt_o), 32'd1);
    check("b2b if_gnt_first", 32'(if_gnt_o), 32'd0);
    step();
    ls_req_i = 1'b0;
    for (int w = 0; w < 3; w++) begin
      mem_gnt_i = (w == 2);
      @(negedge clk);
      check("b2b hold_req", 32'(hold_flag_o), 32'd1);
      check("b2b mem_addr_ls", mem_addr_o, 32'h0000_0200);
      step();
    end
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0000_0077;
    @(negedge clk);
    check("b2b ls_rvalid", 32'(ls_rvalid_o), 32'd1);
    check("b2b ls_rdata", ls_rdata_o, 32'h0000_0077);
    check("b2b if_gnt_same_cycle", 32'(if_gnt_o), 32'd1);
    check("b2b hold_rsp", 32'(hold_flag_o), 32'd1);
    step();
    if_req_i     = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_gnt_i    = 1'b1;
    @(negedge clk);
    check("b2b if_mem_req", 32'(mem_req_o), 32'd1);
    check("b2b if_mem_addr", mem_addr_o, 32'h0000_0180);
    check("b2b if_mem_be", 32'(mem_be_o), 32'hF);
    check("b2b hold_if", 32'(hold_flag_o), 32'd0);
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0000_0099;
    @(negedge clk);
    check("b2b if_rvalid", 32'(if_rvalid_o), 32'd1);
    check("b2b if_rdata", if_rdata_o, 32'h0000_0099);
    check("b2b ls_rvalid_quiet", 32'(ls_rvalid_o), 32'd0);
    step();
    mem_rvalid_i = 1'b0;
    step();

    // Starvation: both held high against a zero-wait memory
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_1000;
    ls_req_i  = 1'b1;
    ls_addr_i = 32'h0000_2000;
    pend = 1'b0;
    n_gr = 0;
    for (int cyc = 0; cyc < 40 && n_gr < 6; cyc++) begin
      mem_rvalid_i = pend;
      mem_gnt_i    = mem_req_o;
      mem_rdata_i  = 32'(cyc);
      @(negedge clk);
      if (if_gnt_o || ls_gnt_o) begin
        check($sformatf("starve order%0d", n_gr), 32'(ls_gnt_o), 32'(exp_order[n_gr]));
        check($sformatf("starve run%0d", n_gr), 32'(dbg_ls_run), 32'(exp_run[n_gr]));
        n_gr++;
      end
      pend_n = mem_req_o & mem_gnt_i;
      step();
      pend = pend_n;
    end
    check("starve grant_count", 32'(n_gr), 32'd6);
    if_req_i = 1'b0;
    ls_req_i = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      mem_rvalid_i = pend;
      mem_gnt_i    = mem_req_o;
      @(negedge clk);
      pend_n = mem_req_o & mem_gnt_i;
      step();
      pend = pend_n;
    end
    mem_rvalid_i = 1'b0;
    mem_gnt_i    = 1'b0;
    @(negedge clk);
    check("starve drained", 32'(dbg_state), 32'd0);
    step();

    // Spurious rvalid and gnt while idle
    mem_rvalid_i = 1'b1;
    mem_gnt_i    = 1'b1;
    mem_rdata_i  = 32'h5555_5555;
    @(negedge clk);
    check("spur if_rvalid", 32'(if_rvalid_o), 32'd0);
    check("spur ls_rvalid", 32'(ls_rvalid_o), 32'd0);
    check("spur if_rdata", if_rdata_o, 32'h0);
    check("spur ls_rdata", ls_rdata_o, 32'h0);
    step();
    mem_rvalid_i = 1'b0;
    mem_gnt_i    = 1'b0;
    @(negedge clk);
    check("spur state_idle", 32'(dbg_state), 32'd0);
    check("spur mem_req", 32'(mem_req_o), 32'd0);
    step();

    // Reset during WAIT
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0500;
    step();
    if_req_i  = 1'b0;
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    @(negedge clk);
    check("rstw in_wait", 32'(dbg_state), 32'd2);
    step();
    #1 rst = 1'b0;
    #1;
    check("rstw mem_req", 32'(mem_req_o), 32'd0);
    check("rstw mem_addr", mem_addr_o, 32'h0);
    check("rstw mem_be", 32'(mem_be_o), 32'd0);
    check("rstw mem_we", 32'(mem_we_o), 32'd0);
    check("rstw if_gnt", 32'(if_gnt_o), 32'd0);
    check("rstw if_rvalid", 32'(if_rvalid_o), 32'd0);
    check("rstw hold", 32'(hold_flag_o), 32'd0);
    check("rstw state", 32'(dbg_state), 32'd0);
    step();
    rst          = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0000_0BAD;
    @(negedge clk);
    check("rstw late_rvalid", 32'(if_rvalid_o), 32'd0);
    check("rstw late_rdata", if_rdata_o, 32'h0);
    step();
    mem_rvalid_i = 1'b0;
    run_vec('{1'b1, 1'b0, 1'b0, 32'h0000_0600, 32'h0, 32'h0, 4'h0, 0, 32'h600D_600D,
              1'b0, 32'h0000_0600, 1'b0, 32'h0, 4'hF, 32'h600D_600D}, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
